// File: rtl/ffe_tap_sequencer_if.sv
// Sample handshake and tap/strobe bus between the upstream source, the tap
// sequencer and the FFE MAC datapath.
interface ffe_tap_sequencer_if #(
  parameter int IN_OUT_BUS_WIDTH = 12,
  parameter int DEPTH            = 4,
  parameter int ADDR_SIZE        = $clog2(DEPTH)
);
  logic signed [IN_OUT_BUS_WIDTH-1:0] x_in;
  logic                               x_valid;
  logic                               x_ready;
  logic        [ADDR_SIZE-1:0]        rd_addr;
  logic signed [IN_OUT_BUS_WIDTH-1:0] rd_data;
  logic                               str_out_n_rst_add_reg;
  logic                               y_valid;
  logic                               busy;

  modport master (
    output x_in, x_valid,
    input  x_ready, rd_addr, rd_data, str_out_n_rst_add_reg, y_valid, busy
  );

  modport slave (
    input  x_in, x_valid,
    output x_ready, rd_addr, rd_data, str_out_n_rst_add_reg, y_valid, busy
  );
endinterface

// File: rtl/ffe_tap_sequencer.sv
// Stores the last DEPTH input samples and walks them out one tap per clock to
// the FFE MAC datapath, then strobes store/clear on the accumulator-done cycle.
module ffe_tap_sequencer #(
  parameter int IN_OUT_BUS_WIDTH = 12,
  parameter int DEPTH            = 4,
  parameter int ADDR_SIZE        = $clog2(DEPTH)
) (
  input  logic              ffe_clk,
  input  logic              rst,
  ffe_tap_sequencer_if.slave bus
);
  localparam logic [0:0]           IDLE     = 1'b0;
  localparam logic [0:0]           ISSUE    = 1'b1;
  localparam logic [ADDR_SIZE-1:0] LAST_TAP = ADDR_SIZE'(DEPTH - 1);
  localparam logic [ADDR_SIZE-1:0] ONE      = ADDR_SIZE'(1);

  logic [0:0]                         state_q, state_d;
  logic [ADDR_SIZE-1:0]               k_q, k_d;
  logic [ADDR_SIZE-1:0]               wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0]               cur_ptr_q, cur_ptr_d;
  logic                               drain_q, drain_d;
  logic signed [IN_OUT_BUS_WIDTH-1:0] hist_q [DEPTH];
  logic signed [IN_OUT_BUS_WIDTH-1:0] hist_d [DEPTH];

  logic                 issuing;
  logic                 last_tap;
  logic                 accept;
  logic [ADDR_SIZE-1:0] rd_ptr;

  assign issuing  = (state_q == ISSUE);
  assign last_tap = issuing && (k_q == LAST_TAP);
  assign accept   = bus.x_valid && bus.x_ready;
  // DEPTH is a power of two, so the pointer subtraction wraps for free.
  assign rd_ptr   = cur_ptr_q - k_q;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    wr_ptr_d  = wr_ptr_q;
    cur_ptr_d = cur_ptr_q;
    drain_d   = last_tap;
    if (accept) begin
      state_d   = ISSUE;
      k_d       = '0;
      cur_ptr_d = wr_ptr_q;
      wr_ptr_d  = wr_ptr_q + ONE;
    end else if (last_tap) begin
      state_d = IDLE;
      k_d     = '0;
    end else if (issuing) begin
      k_d = k_q + ONE;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      hist_d[i] = hist_q[i];
    end
    if (accept) begin
      hist_d[wr_ptr_q] = bus.x_in;
    end
  end

  always_ff @(posedge ffe_clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      wr_ptr_q  <= '0;
      cur_ptr_q <= '0;
      drain_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      wr_ptr_q  <= wr_ptr_d;
      cur_ptr_q <= cur_ptr_d;
      drain_q   <= drain_d;
    end
  end

  // History is cleared only by reset so early taps of the first samples read 0.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hist
    always_ff @(posedge ffe_clk or negedge rst) begin
      if (!rst) begin
        hist_q[gi] <= '0;
      end else begin
        hist_q[gi] <= hist_d[gi];
      end
    end
  end

  // Outside ISSUE the tap bus is forced to zero so the datapath adds nothing.
  assign bus.x_ready               = !issuing || last_tap;
  assign bus.rd_addr               = issuing ? k_q : '0;
  assign bus.rd_data               = issuing ? hist_q[rd_ptr] : '0;
  assign bus.str_out_n_rst_add_reg = drain_q;
  assign bus.y_valid               = drain_q;
  assign bus.busy                  = issuing || drain_q;
endmodule
